// File: rtl/fs4_iq_upconv_pkg.sv
// fs/4 upconverter shared types: FSM states, widths and the
// quadrature lane map {I, -Q, -I, Q}.
package fs4_upconv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNDERRUN
  } state_t;

  localparam int DWIDTH_DEF = 14;
  localparam int LANE_W = DWIDTH_DEF + 2;
  localparam int UNR_FS4 = 4;
  localparam int CNT_W = 8;
  localparam int MAP_W = 32;

  // Wide signed math so negating the most negative input cannot wrap.
  function automatic logic signed [MAP_W-1:0] lane_map(
    input logic [1:0] lane,
    input logic signed [MAP_W-1:0] i,
    input logic signed [MAP_W-1:0] q
  );
    logic signed [MAP_W-1:0] r;
    unique case (lane)
      2'd0: r = i;
      2'd1: r = -q;
      2'd2: r = -i;
      2'd3: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fs4_iq_upconv_if.sv
// Baseband I/Q sample stream with valid/ready handshake.
// master drives samples, slave returns ready.
interface fs4_iq_upconv_if #(
  parameter int DWIDTH = 14
);

  logic signed [DWIDTH:0] iq_i;
  logic signed [DWIDTH:0] iq_q;
  logic iq_valid;
  logic iq_ready;

  modport master (
    output iq_i,
    output iq_q,
    output iq_valid,
    input  iq_ready
  );

  modport slave (
    input  iq_i,
    input  iq_q,
    input  iq_valid,
    output iq_ready
  );

endinterface

// File: rtl/fs4_iq_upconv_iq_skid_reg.sv
// Active/pending sample registers with zero-order-hold counter.
// A sample arriving on the expiry edge bypasses straight to active.
module iq_skid_reg
  import fs4_upconv_pkg::*;
#(
  parameter int DWIDTH = 14,
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  fs4_iq_upconv_if.slave iq,
  output logic act_valid,
  output logic signed [DWIDTH:0] act_i,
  output logic signed [DWIDTH:0] act_q
);

  logic pend_valid;
  logic signed [DWIDTH:0] pend_i;
  logic signed [DWIDTH:0] pend_q;
  logic [CNT_W-1:0] hold_cnt;
  logic accept;
  logic expire;

  assign iq.iq_ready = enable && !pend_valid;
  assign accept = iq.iq_valid && iq.iq_ready;
  assign expire = act_valid && (hold_cnt == CNT_W'(HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid <= 1'b0;
      act_i <= '0;
      act_q <= '0;
      pend_valid <= 1'b0;
      pend_i <= '0;
      pend_q <= '0;
      hold_cnt <= '0;
    end else if (!enable) begin
      act_valid <= 1'b0;
      pend_valid <= 1'b0;
      hold_cnt <= '0;
    end else if (!act_valid || expire) begin
      hold_cnt <= '0;
      if (pend_valid) begin
        act_i <= pend_i;
        act_q <= pend_q;
        act_valid <= 1'b1;
        pend_valid <= 1'b0;
      end else if (accept) begin
        act_i <= iq.iq_i;
        act_q <= iq.iq_q;
        act_valid <= 1'b1;
      end else begin
        act_valid <= 1'b0;
      end
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
      if (accept) begin
        pend_i <= iq.iq_i;
        pend_q <= iq.iq_q;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fs4_iq_upconv.sv
// 4-lane fs/4 quadrature upconverter for the DAC path with
// zero-order hold, underrun zero-fill and sticky underflow flag.
module fs4_iq_upconv
  import fs4_upconv_pkg::*;
#(
  parameter int DWIDTH = LANE_W - 2,
  parameter int UNR = UNR_FS4,
  parameter int HOLD = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic enable,
  fs4_iq_upconv_if.slave iq,
  output logic [UNR-1:0][DWIDTH+1:0] dout,
  output logic dout_valid,
  output logic underflow,
  input  logic clr_underflow
);

  localparam int LW = DWIDTH + 2;

  state_t state;
  state_t state_n;
  logic act_valid;
  logic signed [DWIDTH:0] act_i;
  logic signed [DWIDTH:0] act_q;
  logic signed [MAP_W-1:0] ext_i;
  logic signed [MAP_W-1:0] ext_q;
  logic [UNR-1:0][LW-1:0] dout_n;
  logic uf_set;

  if (UNR != UNR_FS4) begin : g_bad_unr
    $error("fs4_iq_upconv: UNR must be 4");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("fs4_iq_upconv: HOLD must be 1..255");
  end

  iq_skid_reg #(
    .DWIDTH(DWIDTH),
    .HOLD(HOLD)
  ) u_skid (
    .clk(CLK),
    .rst_n(RESET_N),
    .enable(enable),
    .iq(iq),
    .act_valid(act_valid),
    .act_i(act_i),
    .act_q(act_q)
  );

  assign ext_i = {{(MAP_W-DWIDTH-1){act_i[DWIDTH]}}, act_i};
  assign ext_q = {{(MAP_W-DWIDTH-1){act_q[DWIDTH]}}, act_q};

  // State mirrors what dout shows after the next edge.
  always_comb begin
    state_n = state;
    dout_n = '0;
    uf_set = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else if (act_valid) begin
      state_n = RUN;
    end else if (state == IDLE) begin
      state_n = IDLE;
    end else begin
      state_n = UNDERRUN;
    end
    if (state_n == RUN) begin
      for (int k = 0; k < UNR; k++) begin
        dout_n[k] = LW'(lane_map(2'(k), ext_i, ext_q));
      end
    end
    uf_set = (state == RUN) && (state_n == UNDERRUN);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      dout <= '0;
      dout_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      dout <= dout_n;
      dout_valid <= (state_n != IDLE);
      if (uf_set) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fs4_iq_upconv.sv
// Scoreboard bench for fs4_iq_upconv: accepted samples expand into
// time-stamped output slots checked by independent monitors.
module tb_fs4_iq_upconv;

  localparam int DW = 14;
  localparam int HOLD = 4;

  typedef struct {
    int stamp;
    int i;
    int q;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic enable1 = 1'b0;
  logic clr = 1'b0;
  logic [3:0][15:0] dout;
  logic [3:0][15:0] dout1;
  logic dv, uf, dv1, uf1;

  fs4_iq_upconv_if #(.DWIDTH(DW)) bus ();
  fs4_iq_upconv_if #(.DWIDTH(DW)) bus1 ();

  fs4_iq_upconv #(.DWIDTH(DW), .UNR(4), .HOLD(HOLD)) dut (
    .CLK(clk), .RESET_N(rst_n), .enable(enable), .iq(bus),
    .dout(dout), .dout_valid(dv), .underflow(uf),
    .clr_underflow(clr)
  );

  fs4_iq_upconv #(.DWIDTH(DW), .UNR(4), .HOLD(1)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .enable(enable1), .iq(bus1),
    .dout(dout1), .dout_valid(dv1), .underflow(uf1),
    .clr_underflow(1'b0)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  ent_t sq[$];
  ent_t sq1[$];
  int play_time = 0;
  int last_start = 0;
  int last_acc = 0;
  bit played = 0;
  bit chk_off = 1;
  bit en_m = 0;
  bit clr_m = 0;
  bit uf_m = 0;
  bit prev_run = 0;
  bit live, ur;
  int ei, eq;
  bit acc;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int lane(input logic [3:0][15:0] d, input int k);
    logic signed [15:0] s;
    s = d[k];
    return int'(s);
  endfunction

  task automatic model_clear();
    sq.delete();
    played = 0;
    play_time = 0;
    last_start = 0;
    last_acc = 0;
  endtask

  // Main monitor: one output slot per edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!chk_off) begin
        live = 0;
        ei = 0;
        eq = 0;
        if (en_m && sq.size() > 0 && sq[0].stamp == cyc) begin
          live = 1;
          ei = sq[0].i;
          eq = sq[0].q;
          void'(sq.pop_front());
          played = 1;
        end
        ur = en_m && !live && played;
        if (ur && prev_run) uf_m = 1;
        else if (clr_m) uf_m = 0;
        prev_run = live;
        check("dout_valid", int'(dv), int'(live || ur));
        check("lane0", lane(dout, 0), ei);
        check("lane1", lane(dout, 1), -eq);
        check("lane2", lane(dout, 2), -ei);
        check("lane3", lane(dout, 3), eq);
        check("underflow", int'(uf), int'(uf_m));
      end
    end
  end

  // HOLD=1 monitor.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sq1.size() > 0 && sq1[0].stamp == cyc) begin
        check("h1 valid", int'(dv1), 1);
        check("h1 lane0", lane(dout1, 0), sq1[0].i);
        check("h1 lane1", lane(dout1, 1), -sq1[0].q);
        check("h1 lane3", lane(dout1, 3), sq1[0].q);
        void'(sq1.pop_front());
      end
    end
  end

  task automatic cyc_drive(input bit v, input int i, input int q,
                           input bit en, input bit c, output bit a);
    int e, st;
    bit exp_rdy;
    @(negedge clk);
    bus.iq_valid = v;
    bus.iq_i = 15'(i);
    bus.iq_q = 15'(q);
    enable = en;
    clr = c;
    en_m = en;
    clr_m = c;
    e = cyc + 1;
    if (!en) model_clear();
    #1;
    exp_rdy = en && !(last_start > e && last_start > last_acc + 1);
    check("iq_ready", int'(bus.iq_ready), int'(exp_rdy));
    a = v && bus.iq_ready;
    if (a) begin
      st = (play_time > e + 1) ? play_time : e + 1;
      for (int h = 0; h < HOLD; h++) sq.push_back('{st + h, i, q});
      play_time = st + HOLD;
      last_start = st;
      last_acc = e;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) cyc_drive(0, 0, 0, 1, 0, a);
  endtask

  task automatic send(input int i, input int q);
    bit a;
    int tries;
    a = 0;
    tries = 0;
    while (!a && tries < 32) begin
      cyc_drive(1, i, q, 1, 0, a);
      tries++;
    end
    if (!a) begin
      nchk++;
      nerr++;
      $display("FAIL send timeout: got no accept expected accept");
    end
  endtask

  task automatic apply_reset();
    chk_off = 1;
    @(negedge clk);
    #3;
    rst_n = 0;
    #1;
    check("rst dout_valid", int'(dv), 0);
    check("rst lane0", lane(dout, 0), 0);
    check("rst lane2", lane(dout, 2), 0);
    check("rst underflow", int'(uf), 0);
    enable = 0;
    bus.iq_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_clear();
    uf_m = 0;
    prev_run = 0;
    en_m = 0;
    clr_m = 0;
    chk_off = 0;
  endtask

  initial begin
    bus.iq_valid = 0;
    bus.iq_i = '0;
    bus.iq_q = '0;
    bus1.iq_valid = 0;
    bus1.iq_i = '0;
    bus1.iq_q = '0;
    apply_reset();
    check("rst iq_ready", int'(bus.iq_ready), 0);

    idle(1);
    send(1000, -200);
    idle(8);
    cyc_drive(0, 0, 0, 1, 1, acc);
    idle(2);

    // Clear requested on the very edge the next underrun begins.
    send(500, 77);
    while (cyc + 2 < play_time) idle(1);
    cyc_drive(0, 0, 0, 1, 1, acc);
    idle(2);

    send(1, -1);
    send(2, -2);
    send(3, -3);
    idle(16);

    send(-16384, 16383);
    idle(6);

    // Disable while running with pending full.
    send(11, 12);
    send(13, 14);
    cyc_drive(1, 15, 16, 0, 0, acc);
    check("no accept when disabled", int'(acc), 0);
    idle(4);

    // HOLD=1 back-to-back stream.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      enable1 = 1;
      bus1.iq_valid = 1;
      bus1.iq_i = 15'(k);
      bus1.iq_q = 15'(-k);
      #1;
      check("h1 iq_ready", int'(bus1.iq_ready), 1);
      if (bus1.iq_ready) sq1.push_back('{cyc + 2, k, -k});
    end
    @(negedge clk);
    bus1.iq_valid = 0;
    repeat (3) @(negedge clk);
    check("h1 drained", sq1.size(), 0);
    enable1 = 0;

    for (int n = 0; n < 400; n++) begin
      cyc_drive(($urandom % 3) != 0,
                int'($urandom_range(0, 32767)) - 16384,
                int'($urandom_range(0, 32767)) - 16384,
                ($urandom % 50) != 0,
                ($urandom % 20) == 0, acc);
    end
    idle(8);

    send(123, -45);
    idle(1);
    apply_reset();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
